uart_frame_sequencer: RTL

- Central controller for the UART batch datapath.
- After `start`, it captures N_IN received bytes into the input buffer and kicks the processing engine.
- It then streams N_OUT result bytes from the output buffer to the UART transmitter, one byte at a time.
- Sits between the UART RX, the buffer/processing core, and the UART TX inside the top module; it owns all sequencing, addresses and handshakes.

---
 rtl/uart_frame_sequencer_if.sv | 41 ++++
 rtl/uart_frame_sequencer.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/uart_frame_sequencer_if.sv
// +------------------------------------------------------------------+
// | uart_frame_sequencer_if : RX / buffer / engine / TX bus bundle    |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

interface uart_frame_sequencer_if #(
   parameter int AW = 8
);
   logic          start;
   logic          rx_valid;
   logic [7:0]    rx_byte;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [7:0]    wr_data;
   logic          proc_start;
   logic          proc_done;
   logic          rd_en;
   logic [AW-1:0] rd_addr;
   logic [7:0]    rd_data;
   logic          tx_start;
   logic [7:0]    tx_byte;
   logic          tx_busy;
   logic          busy;
   logic          all_done;
   logic          err;

   modport master (
      input  start, rx_valid, rx_byte, proc_done, rd_data, tx_busy,
      output wr_en, wr_addr, wr_data, proc_start, rd_en, rd_addr,
             tx_start, tx_byte, busy, all_done, err
   );

   modport slave (
      output start, rx_valid, rx_byte, proc_done, rd_data, tx_busy,
      input  wr_en, wr_addr, wr_data, proc_start, rd_en, rd_addr,
             tx_start, tx_byte, busy, all_done, err
   );
endinterface

`default_nettype wire

// File: rtl/uart_frame_sequencer.sv
// +------------------------------------------------------------------+
// | uart_frame_sequencer : batch RX capture -> process -> TX stream   |
// | Optional RX timeout: define UART_FRAME_SEQ_TIMEOUT_EN.  Rev 1.0   |
// +------------------------------------------------------------------+
`default_nettype none

module uart_frame_sequencer #(
   parameter int N_IN  = 200,
   parameter int N_OUT = 100,
   parameter int AW    = 8
`ifdef UART_FRAME_SEQ_TIMEOUT_EN
   , parameter int TIMEOUT_CYC = 1000000
`endif
) (
   input  logic                   clk,
   input  logic                   reset,
   uart_frame_sequencer_if.master bus
);

   typedef enum logic [3:0] {
      IDLE, RECV, PROC_KICK, PROC_WAIT, RD_REQ, RD_WAIT, TX_KICK, TX_WAIT, DONE
`ifdef UART_FRAME_SEQ_TIMEOUT_EN
      , ERR
`endif
   } state_t;

   localparam logic [AW-1:0] c_last_in  = AW'(N_IN - 1);
   localparam logic [AW-1:0] c_last_out = AW'(N_OUT - 1);

   state_t        r_state, w_state_nxt;
   logic [AW-1:0] r_in_cnt, w_in_cnt_nxt;
   logic [AW-1:0] r_out_cnt, w_out_cnt_nxt;
   logic          r_wr_en, w_wr_en_nxt;
   logic [AW-1:0] r_wr_addr, w_wr_addr_nxt;
   logic [7:0]    r_wr_data, w_wr_data_nxt;
   logic          r_proc_start, w_proc_start_nxt;
   logic          r_tx_start, w_tx_start_nxt;
   logic [7:0]    r_tx_byte, w_tx_byte_nxt;
`ifdef UART_FRAME_SEQ_TIMEOUT_EN
   localparam logic [31:0] c_timeout = 32'(TIMEOUT_CYC);
   logic [31:0]   r_idle_cnt, w_idle_nxt;
`endif

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state      <= IDLE;
         r_in_cnt     <= '0;
         r_out_cnt    <= '0;
         r_wr_en      <= 1'b0;
         r_wr_addr    <= '0;
         r_wr_data    <= '0;
         r_proc_start <= 1'b0;
         r_tx_start   <= 1'b0;
         r_tx_byte    <= '0;
`ifdef UART_FRAME_SEQ_TIMEOUT_EN
         r_idle_cnt   <= '0;
`endif
      end else begin
         r_state      <= w_state_nxt;
         r_in_cnt     <= w_in_cnt_nxt;
         r_out_cnt    <= w_out_cnt_nxt;
         r_wr_en      <= w_wr_en_nxt;
         r_wr_addr    <= w_wr_addr_nxt;
         r_wr_data    <= w_wr_data_nxt;
         r_proc_start <= w_proc_start_nxt;
         r_tx_start   <= w_tx_start_nxt;
         r_tx_byte    <= w_tx_byte_nxt;
`ifdef UART_FRAME_SEQ_TIMEOUT_EN
         r_idle_cnt   <= w_idle_nxt;
`endif
      end
   end

   always_comb begin
      w_state_nxt      = r_state;
      w_in_cnt_nxt     = r_in_cnt;
      w_out_cnt_nxt    = r_out_cnt;
      w_wr_en_nxt      = 1'b0;
      w_wr_addr_nxt    = r_wr_addr;
      w_wr_data_nxt    = r_wr_data;
      w_proc_start_nxt = 1'b0;
      w_tx_start_nxt   = 1'b0;
      w_tx_byte_nxt    = r_tx_byte;
`ifdef UART_FRAME_SEQ_TIMEOUT_EN
      w_idle_nxt       = '0;
`endif
      case (r_state)
         IDLE, DONE: begin
            if (bus.start) begin
               w_state_nxt  = RECV;
               w_in_cnt_nxt = '0;
            end
         end
         RECV: begin
            if (bus.rx_valid) begin
               w_wr_en_nxt   = 1'b1;
               w_wr_addr_nxt = r_in_cnt;
               w_wr_data_nxt = bus.rx_byte;
               w_in_cnt_nxt  = r_in_cnt + AW'(1);
               if (r_in_cnt == c_last_in) w_state_nxt = PROC_KICK;
            end
`ifdef UART_FRAME_SEQ_TIMEOUT_EN
            // Idle time only counts once the batch has started arriving.
            else if (r_in_cnt != '0) begin
               w_idle_nxt = r_idle_cnt + 32'd1;
               if (w_idle_nxt == c_timeout) w_state_nxt = ERR;
            end
`endif
         end
         PROC_KICK: begin
            w_proc_start_nxt = 1'b1;
            w_state_nxt      = PROC_WAIT;
         end
         PROC_WAIT: begin
            if (bus.proc_done) begin
               w_out_cnt_nxt = '0;
               w_state_nxt   = RD_REQ;
            end
         end
         RD_REQ: w_state_nxt = RD_WAIT;
         RD_WAIT: begin
            w_tx_byte_nxt = bus.rd_data;
            w_state_nxt   = TX_KICK;
         end
         TX_KICK: begin
            if (!bus.tx_busy) begin
               w_tx_start_nxt = 1'b1;
               w_state_nxt    = TX_WAIT;
            end
         end
         TX_WAIT: begin
            // r_tx_start marks the first TX_WAIT cycle, before the
            // transmitter has had a chance to raise busy.
            if (!r_tx_start && !bus.tx_busy) begin
               w_out_cnt_nxt = r_out_cnt + AW'(1);
               w_state_nxt   = (r_out_cnt == c_last_out) ? DONE : RD_REQ;
            end
         end
`ifdef UART_FRAME_SEQ_TIMEOUT_EN
         ERR: begin
            if (bus.start) begin
               w_state_nxt  = RECV;
               w_in_cnt_nxt = '0;
            end
         end
`endif
         default: w_state_nxt = IDLE;
      endcase
   end

   assign bus.wr_en      = r_wr_en;
   assign bus.wr_addr    = r_wr_addr;
   assign bus.wr_data    = r_wr_data;
   assign bus.proc_start = r_proc_start;
   assign bus.rd_en      = (r_state == RD_REQ);
   assign bus.rd_addr    = r_out_cnt;
   assign bus.tx_start   = r_tx_start;
   assign bus.tx_byte    = r_tx_byte;
   assign bus.all_done   = (r_state == DONE);
`ifdef UART_FRAME_SEQ_TIMEOUT_EN
   assign bus.busy       = (r_state != IDLE) && (r_state != DONE) && (r_state != ERR);
   assign bus.err        = (r_state == ERR);
`else
   assign bus.busy       = (r_state != IDLE) && (r_state != DONE);
   assign bus.err        = 1'b0;
`endif

endmodule

`default_nettype wire
